// File: rtl/class_score_accum_pkg.sv
// class_score_pkg: shared widths, class count and FSM state type for class_score_accum
package class_score_pkg;
   localparam int NUM_CLASSES = 10;
   localparam int DEF_PIX_W = 8;
   localparam int DEF_WGT_W = 8;
   localparam int DEF_ACC_W = 26;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
   function automatic int prod_w(input int pix_w, input int wgt_w);
      return pix_w + wgt_w + 1;
   endfunction
endpackage

// File: rtl/class_score_accum_if.sv
// class_score_accum_if: pixel/weight beat stream with valid/ready handshake
interface class_score_accum_if
   import class_score_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int WGT_W = DEF_WGT_W
);
   logic                         pix_valid;
   logic                         pix_ready;
   logic [PIX_W-1:0]             pix_data;
   logic [NUM_CLASSES*WGT_W-1:0] wgt_data;
   modport master (output pix_valid, pix_data, wgt_data, input pix_ready);
   modport slave (input pix_valid, pix_data, wgt_data, output pix_ready);
endinterface

// File: rtl/class_score_accum_mac_lane.sv
// class_mac_lane: one class lane, registered product then accumulate (SCORE_SAT_EN saturates)
module class_mac_lane
   import class_score_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int WGT_W = DEF_WGT_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic [PIX_W-1:0]        pix,
   input  logic signed [WGT_W-1:0] wgt,
   output logic signed [ACC_W-1:0] acc
`ifdef SCORE_SAT_EN
   ,
   output logic                    sat
`endif
);
   localparam int PW = prod_w(PIX_W, WGT_W);
   logic signed [PW-1:0]    prod;
   logic                    pv;
   logic signed [ACC_W-1:0] ext, nxt;
   assign ext = ACC_W'(prod);
`ifdef SCORE_SAT_EN
   logic signed [ACC_W:0] sum;
   logic                  ovf;
   // one guard bit exposes overflow; clip toward the sign of the true sum
   always_comb begin
      sum = {ext[ACC_W-1], ext} + {acc[ACC_W-1], acc};
      ovf = sum[ACC_W] ^ sum[ACC_W-1];
      nxt = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
   end
   always_ff @(posedge clk)
      if (rst || clr) sat <= 1'b0;
      else if (pv && ovf) sat <= 1'b1;
`else
   assign nxt = acc + ext;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
         pv   <= 1'b0;
         acc  <= '0;
      end else begin
         if (en) prod <= PW'($signed({1'b0, pix})) * PW'(wgt);
         pv <= en;
         if (clr) acc <= '0;
         else if (pv) acc <= nxt;
      end
   end
endmodule

// File: rtl/class_score_accum.sv
// class_score_accum: streams one image and emits 10 signed class scores; SCORE_SAT_EN adds saturation and sat_flag
module class_score_accum
   import class_score_pkg::*;
#(
   parameter int NUM_PIX = 784,
   parameter int PIX_W   = DEF_PIX_W,
   parameter int WGT_W   = DEF_WGT_W,
   parameter int ACC_W   = DEF_ACC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   class_score_accum_if.slave      px,
   output logic                    busy,
   output logic                    scores_valid,
   output logic signed [ACC_W-1:0] final0,
   output logic signed [ACC_W-1:0] final1,
   output logic signed [ACC_W-1:0] final2,
   output logic signed [ACC_W-1:0] final3,
   output logic signed [ACC_W-1:0] final4,
   output logic signed [ACC_W-1:0] final5,
   output logic signed [ACC_W-1:0] final6,
   output logic signed [ACC_W-1:0] final7,
   output logic signed [ACC_W-1:0] final8,
   output logic signed [ACC_W-1:0] final9
`ifdef SCORE_SAT_EN
   ,
   output logic                    sat_flag
`endif
);
   localparam int CW = $clog2(NUM_PIX + 1);
   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt;
   logic                    go, beat, last, drain_d;
   logic signed [ACC_W-1:0] acc [NUM_CLASSES];
   logic signed [ACC_W-1:0] fin [NUM_CLASSES];
   always_comb begin
      go        = start && (state == IDLE || state == DONE);
      beat      = px.pix_valid && state == ACCUM;
      last      = beat && cnt == CW'(NUM_PIX - 1);
      state_nxt = go ? ACCUM : last ? DRAIN : state == DRAIN ? DONE : state;
   end
   assign px.pix_ready = state == ACCUM;
   assign busy         = state == ACCUM || state == DRAIN;
   // drain_d marks the edge after the final add, so finals see the complete sum
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         drain_d      <= 1'b0;
         scores_valid <= 1'b0;
         fin          <= '{default: '0};
      end else begin
         state        <= state_nxt;
         cnt          <= go ? '0 : beat ? cnt + CW'(1) : cnt;
         drain_d      <= state == DRAIN;
         scores_valid <= drain_d;
         if (drain_d) fin <= acc;
      end
   end
`ifdef SCORE_SAT_EN
   logic [NUM_CLASSES-1:0] sat;
   assign sat_flag = |sat;
`endif
   for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_lane
      class_mac_lane #(.PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (go),
         .en  (beat),
         .pix (px.pix_data),
         .wgt (px.wgt_data[c*WGT_W +: WGT_W]),
         .acc (acc[c])
`ifdef SCORE_SAT_EN
         ,
         .sat (sat[c])
`endif
      );
   end
   assign final0 = fin[0];
   assign final1 = fin[1];
   assign final2 = fin[2];
   assign final3 = fin[3];
   assign final4 = fin[4];
   assign final5 = fin[5];
   assign final6 = fin[6];
   assign final7 = fin[7];
   assign final8 = fin[8];
   assign final9 = fin[9];
endmodule

// File: tb/tb_class_score_accum.sv
// tb_class_score_accum: table-driven frames with a score scoreboard plus reset, bubble and back-to-back sequences
module tb_class_score_accum;
   localparam int NP = 784;
   typedef struct packed {
      logic [7:0]       pix;
      logic [79:0]      wgt;
      logic [9:0][31:0] ex;
   } vec_t;
   typedef struct packed {
      logic [9:0][31:0] ex;
      logic             lat;
      int               t0;
   } want_t;
   logic clk = 0, rst = 1, start = 0;
   logic busy, scores_valid;
   logic signed [25:0] f [10];
`ifdef SCORE_SAT_EN
   logic sat_flag;
`endif
   int cyc = 0, checks = 0, errors = 0;
   want_t want_q[$];
   vec_t tbl[4];
   bit hold_en = 0;
   logic [9:0][31:0] hold_ex;
   logic sv_prev = 0;
   class_score_accum_if #(.PIX_W(8), .WGT_W(8)) px ();
   class_score_accum #(.NUM_PIX(NP), .PIX_W(8), .WGT_W(8), .ACC_W(26)) dut (
      .clk(clk), .rst(rst), .start(start), .px(px.slave), .busy(busy), .scores_valid(scores_valid),
      .final0(f[0]), .final1(f[1]), .final2(f[2]), .final3(f[3]), .final4(f[4]),
      .final5(f[5]), .final6(f[6]), .final7(f[7]), .final8(f[8]), .final9(f[9])
`ifdef SCORE_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (scores_valid) begin
         chk("scores_valid_pulse", sv_prev, 0);
         if (want_q.size() == 0) chk("scores_valid_unexpected", want_q.size(), 1);
         else begin
            want_t w;
            w = want_q.pop_front();
            for (int c = 0; c < 10; c++) chk($sformatf("final%0d", c), f[c], $signed(w.ex[c]));
            if (w.lat) chk("latency", cyc - w.t0, NP + 2);
         end
      end
      sv_prev = scores_valid;
   end

   task automatic run_frame(input logic [7:0] pc, input logic [79:0] wc, input bit rnd, input int duty,
                            input bit inj, input bit use_tbl, input logic [9:0][31:0] ex_in);
      int m[10];
      int n, it, t0;
      bit v;
      logic [7:0] p;
      logic [79:0] w;
      want_t e;
      for (int c = 0; c < 10; c++) m[c] = 0;
      px.pix_valid = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("ready_in_accum", px.pix_ready, 1);
      chk("busy_in_accum", busy, 1);
      n = 0; it = 0; t0 = -1;
      while (n < NP && it < 8 * NP) begin
         v = duty >= 100 || $urandom_range(99) < duty;
         p = rnd ? 8'($urandom) : pc;
         w = rnd ? {16'($urandom), 32'($urandom), 32'($urandom)} : wc;
         px.pix_valid = v;
         px.pix_data = p;
         px.wgt_data = w;
         start = inj && it == 50;
         if (v && px.pix_ready) begin
            if (t0 < 0) t0 = cyc;
            n++;
            for (int c = 0; c < 10; c++) m[c] += int'(p) * int'($signed(w[c*8 +: 8]));
         end
         if (hold_en && it == NP / 2)
            for (int c = 0; c < 10; c++) chk("final_hold", f[c], $signed(hold_ex[c]));
         @(posedge clk); #1;
         it++;
      end
      px.pix_valid = 0;
      start = 0;
      chk("frame_beats", n, NP);
      chk("ready_drop", px.pix_ready, 0);
      chk("busy_drain", busy, 1);
      for (int c = 0; c < 10; c++) e.ex[c] = use_tbl ? ex_in[c] : m[c];
      e.lat = duty >= 100;
      e.t0 = t0;
      want_q.push_back(e);
   endtask

   task automatic wait_scores();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (want_q.size() == 0) break;
      end
      chk("scores_timeout", want_q.size(), 0);
      want_q.delete();
      chk("busy_done", busy, 0);
   endtask

   initial begin
      logic [9:0][31:0] zero_ex;
      zero_ex = '0;
      for (int c = 0; c < 10; c++) begin
         tbl[0].pix = 8'd1;   tbl[0].wgt[c*8 +: 8] = 8'(c);            tbl[0].ex[c] = NP * c;
         tbl[1].pix = 8'd255; tbl[1].wgt[c*8 +: 8] = 8'h00;            tbl[1].ex[c] = 0;
         tbl[2].pix = 8'd200; tbl[2].wgt[c*8 +: 8] = 8'hff;            tbl[2].ex[c] = -NP * 200;
         tbl[3].pix = 8'd37;  tbl[3].wgt[c*8 +: 8] = 8'(c * 13 - 60);  tbl[3].ex[c] = NP * 37 * (c * 13 - 60);
      end
      tbl[1].wgt[7:0] = 8'h80;
      tbl[1].wgt[79:72] = 8'h7f;
      tbl[1].ex[0] = -25589760;
      tbl[1].ex[9] = 25389840;
      px.pix_valid = 0; px.pix_data = 0; px.wgt_data = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      for (int c = 0; c < 10; c++) chk("reset_final", f[c], 0);
      chk("reset_scores_valid", scores_valid, 0);
      chk("reset_ready", px.pix_ready, 0);
      chk("reset_busy", busy, 0);

      for (int i = 0; i < 4; i++) begin
         run_frame(tbl[i].pix, tbl[i].wgt, 0, 100, 0, 1, tbl[i].ex);
         wait_scores();
      end

      start = 1;
      @(posedge clk); #1;
      start = 0;
      px.pix_valid = 1; px.pix_data = 8'd9; px.wgt_data = tbl[3].wgt;
      repeat (100) @(posedge clk);
      #1 rst = 1;
      @(posedge clk); #1;
      rst = 0;
      px.pix_valid = 0;
      for (int c = 0; c < 10; c++) chk("abort_final", f[c], 0);
      chk("abort_ready", px.pix_ready, 0);
      chk("abort_busy", busy, 0);
      chk("abort_scores_valid", scores_valid, 0);
      repeat (8) @(posedge clk);
      #1;

      run_frame(8'd0, 80'd0, 1, 40, 1, 0, zero_ex);
      wait_scores();

      run_frame(tbl[3].pix, tbl[3].wgt, 0, 100, 0, 1, tbl[3].ex);
      for (int i = 0; i < 10 && !scores_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("b2b_scores_valid_seen", scores_valid, 1);
      hold_en = 1;
      hold_ex = tbl[3].ex;
      run_frame(8'd0, tbl[2].wgt, 0, 100, 0, 1, zero_ex);
      hold_en = 0;
      wait_scores();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
